// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, blank
// and start-of-line/frame pulses, all aligned to the counter values shown.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_ACTIVE  = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   CW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [CW-1:0] hcount_d, hcount_q;
  logic [CW-1:0] vcount_d, vcount_q;
  logic          hsync_d, hsync_q;
  logic          vsync_d, vsync_q;
  logic          hblnk_d, hblnk_q;
  logic          vblnk_d, vblnk_q;
  logic          line_start_d, line_start_q;
  logic          frame_start_d, frame_start_q;

  // Next counter values; flags are decoded from these so that after the
  // register they describe exactly the counters shown in the same cycle.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + CNT_ONE;
        end
      end else begin
        hcount_d = hcount_q + CNT_ONE;
      end
    end else begin
      hcount_d = hcount_q;
    end

    hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    hblnk_d = (hcount_d >= H_ACT_END);
    vblnk_d = (vcount_d >= V_ACT_END);
  end

  // Output registers with synchronous active-low reset to an idle raster origin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance and a tiny inverted-
// polarity instance, each checked every cycle against a queued reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        ls;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n0, en0, rst_n1, en1;
  logic [10:0] hcount0, vcount0, hcount1, vcount1;
  logic        hsync0, vsync0, hblnk0, vblnk0, line_start0, frame_start0;
  logic        hsync1, vsync1, hblnk1, vblnk1, line_start1, frame_start1;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fs_last  = -1;
  int   m0h = 0, m0v = 0, m1h = 0, m1v = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n0), .en(en0),
    .hcount(hcount0), .vcount(vcount0), .hsync(hsync0), .vsync(vsync0),
    .hblnk(hblnk0), .vblnk(vblnk0), .line_start(line_start0), .frame_start(frame_start0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(11)
  ) dut1 (
    .clk(clk), .rst_n(rst_n1), .en(en1),
    .hcount(hcount1), .vcount(vcount1), .hsync(hsync1), .vsync(vsync1),
    .hblnk(hblnk1), .vblnk(vblnk1), .line_start(line_start1), .frame_start(frame_start1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference raster advance for one clock edge.
  task automatic adv(inout int h, inout int v, output bit l, output bit f,
                     input bit rst, input bit e, input int ht, input int vt);
    l = 1'b0;
    f = 1'b0;
    if (rst) begin
      h = 0;
      v = 0;
    end else if (e) begin
      h++;
      if (h == ht) begin
        h = 0;
        l = 1'b1;
        v++;
        if (v == vt) begin
          v = 0;
          f = 1'b1;
        end
      end
    end
  endtask

  function automatic exp_t mk(input int h, input int v, input bit l, input bit f,
                              input int ha, input int hf, input int hw,
                              input int va, input int vf, input int vw,
                              input bit hp, input bit vp);
    exp_t e;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hs = (h >= ha + hf && h < ha + hf + hw) ? hp : !hp;
    e.vs = (v >= va + vf && v < va + vf + vw) ? vp : !vp;
    e.hb = (h >= ha);
    e.vb = (v >= va);
    e.ls = l;
    e.fs = f;
    return e;
  endfunction

  task automatic cmp_all(input string p, input exp_t o, input exp_t x);
    chk({p, ".hcount"},      32'(o.h),  32'(x.h));
    chk({p, ".vcount"},      32'(o.v),  32'(x.v));
    chk({p, ".hsync"},       32'(o.hs), 32'(x.hs));
    chk({p, ".vsync"},       32'(o.vs), 32'(x.vs));
    chk({p, ".hblnk"},       32'(o.hb), 32'(x.hb));
    chk({p, ".vblnk"},       32'(o.vb), 32'(x.vb));
    chk({p, ".line_start"},  32'(o.ls), 32'(x.ls));
    chk({p, ".frame_start"}, 32'(o.fs), 32'(x.fs));
  endtask

  // One clock: drive inputs, queue model expectations, then compare after the edge.
  task automatic tick(input bit r0, input bit e0, input bit r1, input bit e1);
    bit   l, f;
    exp_t x, o;
    rst_n0 = r0; en0 = e0; rst_n1 = r1; en1 = e1;
    adv(m0h, m0v, l, f, !r0, e0, 1056, 628);
    q0.push_back(mk(m0h, m0v, l, f, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1));
    adv(m1h, m1v, l, f, !r1, e1, 8, 6);
    q1.push_back(mk(m1h, m1v, l, f, 4, 1, 2, 3, 1, 1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    cyc++;
    x = q0.pop_front();
    o = '{hcount0, vcount0, hsync0, vsync0, hblnk0, vblnk0, line_start0, frame_start0};
    cmp_all("d0", o, x);
    x = q1.pop_front();
    o = '{hcount1, vcount1, hsync1, vsync1, hblnk1, vblnk1, line_start1, frame_start1};
    cmp_all("d1", o, x);
    if (!r1) begin
      fs_last = -1;
    end else if (frame_start1) begin
      if (fs_last >= 0) chk("d1.fs_period", 32'(cyc - fs_last), 32'd48);
      fs_last = cyc;
    end
  endtask

  initial begin
    int  hs_cnt;
    int  ls_cnt;
    int  fs_cnt;
    bit  hb_prev;

    // Reset held for three clocks with enable high.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst.hcount", 32'(hcount0), 32'd0);
    chk("rst.hsync",  32'(hsync0),  32'd0);
    chk("rst.vsync",  32'(vsync0),  32'd0);
    chk("rst.fs",     32'(frame_start0), 32'd0);
    chk("rst.hsync_inv", 32'(hsync1), 32'd1);

    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("first.hcount", 32'(hcount0), 32'd1);

    // Horizontal sweep up to the end of line 0.
    hs_cnt  = 0;
    hb_prev = hblnk0;
    for (int i = 0; i < 2000 && m0h != 1054; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      if (hsync0) hs_cnt++;
      if (hblnk0 && !hb_prev) chk("hblnk_rise", 32'(hcount0), 32'd800);
      hb_prev = hblnk0;
    end
    chk("sweep.hcount", 32'(hcount0), 32'd1054);
    chk("hsync_width",  32'(hs_cnt),  32'd128);

    // Enable gating across the 1055 -> 0 wrap: 1, 0, 0, 1, 1.
    ls_cnt = 0;
    tick(1'b1, 1'b1, 1'b1, 1'b1); ls_cnt += int'(line_start0);
    chk("gate.h1055", 32'(hcount0), 32'd1055);
    tick(1'b1, 1'b0, 1'b1, 1'b1); ls_cnt += int'(line_start0);
    tick(1'b1, 1'b0, 1'b1, 1'b1); ls_cnt += int'(line_start0);
    chk("gate.hold", 32'(hcount0), 32'd1055);
    tick(1'b1, 1'b1, 1'b1, 1'b1); ls_cnt += int'(line_start0);
    chk("gate.wrap_h",  32'(hcount0), 32'd0);
    chk("gate.wrap_v",  32'(vcount0), 32'd1);
    chk("gate.wrap_ls", 32'(line_start0), 32'd1);
    tick(1'b1, 1'b1, 1'b1, 1'b1); ls_cnt += int'(line_start0);
    chk("gate.ls_once", 32'(ls_cnt), 32'd1);

    // Reset mid-line inside the hsync window of the default instance.
    for (int i = 0; i < 2000 && m0h != 900; i++) tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid0.pre_hsync", 32'(hsync0), 32'd1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    chk("mid0.hcount", 32'(hcount0), 32'd0);
    chk("mid0.vcount", 32'(vcount0), 32'd0);
    chk("mid0.hsync",  32'(hsync0),  32'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid0.restart", 32'(hcount0), 32'd1);

    // Reset of the small instance inside both sync windows (h=5, v=4).
    for (int i = 0; i < 200 && !(m1h == 5 && m1v == 4); i++) tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("mid1.pre_vsync", 32'(vsync1), 32'd0);
    chk("mid1.pre_hsync", 32'(hsync1), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid1.vsync", 32'(vsync1), 32'd1);
    chk("mid1.hsync", 32'(hsync1), 32'd1);
    chk("mid1.fs",    32'(frame_start1), 32'd0);
    chk("mid1.ls",    32'(line_start1),  32'd0);

    // Two full small frames after release: frame_start at 48 and 96 clocks.
    fs_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      fs_cnt += int'(frame_start1);
      if (i == 47) chk("frame1.fs_at_48", 32'(frame_start1), 32'd1);
    end
    chk("frame1.fs_count", 32'(fs_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
